// File: rtl/dcache_pkg.sv
// Shared data-cache types: requester port ids, arbiter state, arbiter defaults.
package dcache_pkg;

   localparam int XLEN = 32;

   // Longest run of lost arbitrations before a waiting port is forced to win.
   localparam int DCACHE_ARB_MAX_WAIT = 16;

   typedef enum logic [1:0] {
      PTW_PORT        = 2'd0,
      LOAD_UNIT_PORT  = 2'd1,
      STORE_UNIT_PORT = 2'd2
   } request_port_select_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_WAIT_GNT,
      ARB_BUSY
   } dcache_arb_state_t;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Bundle between the CPU request ports, the arbiter and the cache controller.
//
// Handshake: a port raises port_req_i and holds it until it sees a one-cycle
// port_gnt_o pulse for itself. The arbiter raises cache_req_o and holds
// cache_port_sel_o stable until the controller pulses cache_gnt_i; the
// transaction then stays open until the controller pulses cache_done_i, in
// the same cycle of which port_rvalid_o/port_rdata_o reach the owning port.
// The master modport is the arbiter's view, the slave modport is the view of
// the ports plus the controller.
interface dcache_port_arbiter_if #(
   parameter int NumPorts = 3
);
   import dcache_pkg::*;

   logic [NumPorts-1:0]  port_req_i;
   logic [NumPorts-1:0]  port_gnt_o;
   logic [NumPorts-1:0]  port_rvalid_o;
   logic [XLEN-1:0]      port_rdata_o;
   logic                 cache_req_o;
   request_port_select_t cache_port_sel_o;
   logic                 cache_gnt_i;
   logic                 cache_done_i;
   logic [XLEN-1:0]      cache_rdata_i;
   logic                 busy_o;

   modport master (
      input  port_req_i, cache_gnt_i, cache_done_i, cache_rdata_i,
      output port_gnt_o, port_rvalid_o, port_rdata_o, cache_req_o,
             cache_port_sel_o, busy_o
   );

   modport slave (
      output port_req_i, cache_gnt_i, cache_done_i, cache_rdata_i,
      input  port_gnt_o, port_rvalid_o, port_rdata_o, cache_req_o,
             cache_port_sel_o, busy_o
   );

endinterface

// File: rtl/dcache_rr_select.sv
// Combinational winner pick: aged ports first (lowest index), then PTW when
// it has priority, then round-robin starting at rr_ptr.
module dcache_rr_select #(
   parameter int NumPorts = 3,
   parameter int IdxW     = 2
) (
   input  logic [NumPorts-1:0] req,
   input  logic [IdxW-1:0]     rr_ptr,
   input  logic [NumPorts-1:0] aged,
   input  logic                ptw_priority,
   output logic [NumPorts-1:0] winner_oh,
   output logic [IdxW-1:0]     winner_idx,
   output logic                valid
);

   logic [NumPorts-1:0] aged_req;

   assign aged_req = aged & req;

   // Scan loops run downwards so the last hit, i.e. the first in order, wins.
   always_comb begin
      int cand;
      cand       = 0;
      winner_idx = '0;
      valid      = |req;
      if (|aged_req) begin
         for (int i = NumPorts - 1; i >= 0; i--) begin
            if (aged_req[i]) winner_idx = IdxW'(i);
         end
      end else if (ptw_priority && req[0]) begin
         winner_idx = '0;
      end else begin
         for (int k = NumPorts - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr) + k) % NumPorts;
            if (req[cand]) winner_idx = IdxW'(cand);
         end
      end
      winner_oh = valid ? (NumPorts'(1) << winner_idx) : '0;
   end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single-request data-cache controller between PTW, load and store
// ports; owns the controller from selection until the completion pulse.
module dcache_port_arbiter
   import dcache_pkg::*;
#(
   parameter int NumPorts      = 3,
   parameter bit PtwPriority   = 1'b1,
   parameter int MaxWait       = DCACHE_ARB_MAX_WAIT,
   parameter bit EnableAsserts = 1'b1,
   localparam int AgeW         = $clog2(MaxWait + 1)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   dcache_port_arbiter_if.master        bus,
   output dcache_arb_state_t            dbg_state,
   output logic [NumPorts-1:0][AgeW-1:0] dbg_age,
   output logic                         dbg_proto_err
);

   localparam int IdxW = $bits(request_port_select_t);

   dcache_arb_state_t              state;
   request_port_select_t           owner;
   logic [IdxW-1:0]                rr_ptr;
   logic [NumPorts-1:0][AgeW-1:0]  age;

   logic [NumPorts-1:0] aged;
   logic [NumPorts-1:0] win_oh;
   logic [IdxW-1:0]     win_idx;
   logic                win_valid;
   logic [NumPorts-1:0] owner_oh;

   logic                cache_req;
   logic [IdxW-1:0]     sel;
   logic                gnt_fire;
   logic [NumPorts-1:0] port_gnt;
   logic [NumPorts-1:0] port_rvalid;
   logic [XLEN-1:0]     port_rdata;
   logic                busy;
   logic                done_err;
   logic                drop_err;

   // Next round-robin start after a grant, never landing on PTW when PTW has
   // its own priority lane.
   function automatic logic [IdxW-1:0] rr_after(input logic [IdxW-1:0] g);
      int n;
      n = (int'(g) + 1) % NumPorts;
      if (PtwPriority && n == 0) n = 1;
      return IdxW'(n);
   endfunction

   // A port is aged once its counter saturates.
   always_comb begin
      for (int i = 0; i < NumPorts; i++) aged[i] = (age[i] == AgeW'(MaxWait));
   end

   assign owner_oh = NumPorts'(1) << owner;

   dcache_rr_select #(
      .NumPorts (NumPorts),
      .IdxW     (IdxW)
   ) u_rr_select (
      .req          (bus.port_req_i),
      .rr_ptr       (rr_ptr),
      .aged         (aged),
      .ptw_priority (PtwPriority),
      .winner_oh    (win_oh),
      .winner_idx   (win_idx),
      .valid        (win_valid)
   );

   // Request, grant and completion routing; selection is live only in IDLE.
   always_comb begin
      cache_req   = 1'b0;
      sel         = owner;
      gnt_fire    = 1'b0;
      port_gnt    = '0;
      port_rvalid = '0;
      port_rdata  = '0;
      busy        = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (win_valid) begin
               cache_req = 1'b1;
               sel       = win_idx;
               gnt_fire  = bus.cache_gnt_i;
               if (bus.cache_gnt_i) port_gnt = win_oh;
            end
         end
         ARB_WAIT_GNT: begin
            cache_req = 1'b1;
            gnt_fire  = bus.cache_gnt_i;
            if (bus.cache_gnt_i) port_gnt = owner_oh;
         end
         ARB_BUSY: begin
            busy = 1'b1;
            if (bus.cache_done_i) begin
               port_rvalid = owner_oh;
               port_rdata  = bus.cache_rdata_i;
            end
         end
         default: ;
      endcase
   end

   assign bus.cache_req_o      = cache_req;
   assign bus.cache_port_sel_o = request_port_select_t'(sel);
   assign bus.port_gnt_o       = port_gnt;
   assign bus.port_rvalid_o    = port_rvalid;
   assign bus.port_rdata_o     = port_rdata;
   assign bus.busy_o           = busy;

   // Ownership FSM: pick in IDLE, hold selection until gnt, hold until done.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= ARB_IDLE;
         owner <= PTW_PORT;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (win_valid) begin
                  owner <= request_port_select_t'(sel);
                  state <= bus.cache_gnt_i ? ARB_BUSY : ARB_WAIT_GNT;
               end
            end
            ARB_WAIT_GNT: if (bus.cache_gnt_i) state <= ARB_BUSY;
            ARB_BUSY:     if (bus.cache_done_i) state <= ARB_IDLE;
            default:      state <= ARB_IDLE;
         endcase
      end
   end

   // Fairness bookkeeping: losers age on every grant, idle ports forget.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         age    <= '0;
         rr_ptr <= IdxW'(LOAD_UNIT_PORT);
      end else begin
         for (int i = 0; i < NumPorts; i++) begin
            if (!bus.port_req_i[i]) begin
               age[i] <= '0;
            end else if (gnt_fire) begin
               if (sel == IdxW'(i))  age[i] <= '0;
               else if (!aged[i])    age[i] <= age[i] + AgeW'(1);
            end
         end
         if (gnt_fire && sel != IdxW'(PTW_PORT)) rr_ptr <= rr_after(sel);
      end
   end

   // A completion outside BUSY and an owner dropping its request while the
   // selection is frozen are both controller/port protocol violations.
   assign done_err = bus.cache_done_i && (state != ARB_BUSY);
   assign drop_err = (state == ARB_WAIT_GNT) && !(|(bus.port_req_i & owner_oh));

   assign dbg_state     = state;
   assign dbg_age       = age;
   assign dbg_proto_err = done_err | drop_err;

   if (EnableAsserts) begin : g_asserts
      a_done_only_in_busy : assert property (@(posedge clk_i) disable iff (!rst_ni) !done_err);
      a_owner_holds_req   : assert property (@(posedge clk_i) disable iff (!rst_ni) !drop_err);
   end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: transaction-level reference model of the
// arbitration rules (ages, PTW lane, round-robin pointer) plus a read-data
// scoreboard; directed scenarios followed by randomized traffic.
module tb_dcache_port_arbiter;
   import dcache_pkg::*;

   localparam int N       = 3;
   localparam int MAXW    = 4;
   localparam bit PTW_PRI = 1'b1;
   localparam int AGE_W   = $clog2(MAXW + 1);

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dcache_port_arbiter_if #(.NumPorts(N)) bus ();

   dcache_arb_state_t           dbg_state;
   logic [N-1:0][AGE_W-1:0]     dbg_age;
   logic                        dbg_proto_err;

   dcache_port_arbiter #(
      .NumPorts      (N),
      .PtwPriority   (PTW_PRI),
      .MaxWait       (MAXW),
      .EnableAsserts (1'b0)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .bus           (bus),
      .dbg_state     (dbg_state),
      .dbg_age       (dbg_age),
      .dbg_proto_err (dbg_proto_err)
   );

   // ---------------- model / scoreboard ----------------
   int              errors = 0;
   int              checks = 0;
   int              m_age[N];
   int              m_rr;
   logic [N-1:0]    req_vec;
   logic [XLEN-1:0] exp_q[$];

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m_age[i] = 0;
      m_rr = 1;
   endfunction

   function automatic int model_winner(input logic [N-1:0] r);
      for (int i = 0; i < N; i++) if (r[i] && m_age[i] == MAXW) return i;
      if (PTW_PRI && r[0]) return 0;
      for (int k = 0; k < N; k++) if (r[(m_rr + k) % N]) return (m_rr + k) % N;
      return -1;
   endfunction

   function automatic void model_grant(input int w);
      for (int i = 0; i < N; i++) begin
         if (!req_vec[i] || i == w) m_age[i] = 0;
         else if (m_age[i] < MAXW)  m_age[i] = m_age[i] + 1;
      end
      if (w != 0) begin
         m_rr = (w + 1) % N;
         if (PTW_PRI && m_rr == 0) m_rr = 1;
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic quiesce();
      req_vec = '0;
      bus.port_req_i = req_vec;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      step();
   endtask

   // Runs from the IDLE arbitration cycle to the cycle after the grant.
   // Returns the port the DUT actually granted (-1 if none).
   task automatic grant_phase(input int gnt_delay, input logic [N-1:0] late_req,
                              input int late_cycle, input logic [N-1:0] rereq,
                              input logic [XLEN-1:0] rdata, output int w, output int obs);
      logic [N-1:0] oh;
      w   = model_winner(req_vec);
      obs = -1;
      oh  = N'(1) << w;
      exp_q.push_back(rdata);
      for (int c = 0; c <= gnt_delay; c++) begin
         if (c == late_cycle) begin
            req_vec = req_vec | late_req;
            bus.port_req_i = req_vec;
         end
         bus.cache_gnt_i = (c == gnt_delay);
         #2;
         checks++;
         if (bus.cache_req_o !== 1'b1) begin
            errors++; $display("FAIL cache_req c=%0d: got %b want 1", c, bus.cache_req_o);
         end
         checks++;
         if (bus.cache_port_sel_o !== 2'(w)) begin
            errors++; $display("FAIL port_sel c=%0d: got %0d want %0d", c, bus.cache_port_sel_o, w);
         end
         checks++;
         if (bus.port_gnt_o !== ((c == gnt_delay) ? oh : '0)) begin
            errors++; $display("FAIL port_gnt c=%0d: got %b want %b", c, bus.port_gnt_o,
                               (c == gnt_delay) ? oh : 3'b000);
         end
         checks++;
         if (bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL busy_pre_gnt c=%0d: got %b want 0", c, bus.busy_o);
         end
         if (c == gnt_delay) begin
            for (int i = 0; i < N; i++) if (bus.port_gnt_o[i] === 1'b1) obs = i;
            model_grant(w);
         end
         step();
         bus.cache_gnt_i = 1'b0;
         if (c == gnt_delay && !rereq[w]) begin
            req_vec[w] = 1'b0;
            bus.port_req_i = req_vec;
         end
      end
   endtask

   // BUSY cycles up to and including the completion; stray gnts are driven
   // to confirm they are ignored while no request is outstanding.
   task automatic busy_phase(input int w, input int done_delay);
      logic [N-1:0]    oh;
      logic [XLEN-1:0] want;
      oh = N'(1) << w;
      for (int c = 1; c <= done_delay; c++) begin
         bus.cache_done_i  = (c == done_delay);
         bus.cache_rdata_i = (c == done_delay) ? exp_q[0] : XLEN'($urandom);
         bus.cache_gnt_i   = 1'($urandom_range(0, 1));
         #2;
         checks++;
         if (bus.busy_o !== 1'b1 || bus.cache_req_o !== 1'b0) begin
            errors++; $display("FAIL busy_phase c=%0d: busy=%b req=%b want busy=1 req=0",
                               c, bus.busy_o, bus.cache_req_o);
         end
         checks++;
         if (bus.cache_port_sel_o !== 2'(w) || bus.port_gnt_o !== '0) begin
            errors++; $display("FAIL busy_sel c=%0d: sel=%0d gnt=%b want sel=%0d gnt=000",
                               c, bus.cache_port_sel_o, bus.port_gnt_o, w);
         end
         checks++;
         if (bus.port_rvalid_o !== ((c == done_delay) ? oh : '0)) begin
            errors++; $display("FAIL rvalid c=%0d: got %b want %b", c, bus.port_rvalid_o,
                               (c == done_delay) ? oh : 3'b000);
         end
         if (c == done_delay) begin
            want = exp_q.pop_front();
            checks++;
            if (bus.port_rdata_o !== want) begin
               errors++; $display("FAIL rdata: got %h want %h", bus.port_rdata_o, want);
            end
         end
         step();
         bus.cache_done_i = 1'b0;
         bus.cache_gnt_i  = 1'b0;
      end
   endtask

   task automatic arbitrate(input int gnt_delay, input int done_delay, input logic [N-1:0] rereq,
                            input logic [XLEN-1:0] rdata, output int obs);
      int w;
      grant_phase(gnt_delay, '0, -1, rereq, rdata, w, obs);
      busy_phase(w, done_delay);
   endtask

   task automatic check_ages(input string tag);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (dbg_age[i] !== AGE_W'(m_age[i])) begin
            errors++; $display("FAIL age_%s[%0d]: got %0d want %0d", tag, i, dbg_age[i], m_age[i]);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (bus.cache_req_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         errors++; $display("FAIL reset_req_busy: req=%b busy=%b want 0 0", bus.cache_req_o, bus.busy_o);
      end
      checks++;
      if (bus.port_gnt_o !== '0 || bus.port_rvalid_o !== '0) begin
         errors++; $display("FAIL reset_gnt_rvalid: gnt=%b rvalid=%b want 000 000",
                            bus.port_gnt_o, bus.port_rvalid_o);
      end
      checks++;
      if (bus.port_rdata_o !== '0) begin
         errors++; $display("FAIL reset_rdata: got %h want 0", bus.port_rdata_o);
      end
      checks++;
      if (bus.cache_port_sel_o !== PTW_PORT) begin
         errors++; $display("FAIL reset_sel: got %0d want 0", bus.cache_port_sel_o);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (dbg_state !== ARB_IDLE) begin
         errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ARB_IDLE);
      end
      check_ages("reset");
   endtask

   task automatic test_single_load();
      int obs;
      req_vec = 3'b010;
      bus.port_req_i = req_vec;
      arbitrate(0, 3, 3'b000, 32'hDEADBEEF, obs);
      check_ages("single");
   endtask

   task automatic test_priority();
      int obs;
      quiesce();
      req_vec = 3'b111;
      bus.port_req_i = req_vec;
      arbitrate(0, 1, 3'b110, XLEN'($urandom), obs);
      checks++;
      if (obs != 0) begin
         errors++; $display("FAIL prio_first: granted %0d want 0", obs);
      end
      for (int k = 0; k < 3; k++) arbitrate(0, 1, 3'b110, XLEN'($urandom), obs);
      check_ages("prio");
   endtask

   task automatic test_frozen_select();
      int w, obs;
      quiesce();
      req_vec = 3'b010;
      bus.port_req_i = req_vec;
      grant_phase(4, 3'b001, 2, 3'b000, XLEN'($urandom), w, obs);
      busy_phase(w, 2);
      arbitrate(0, 1, 3'b000, XLEN'($urandom), obs);
      checks++;
      if (obs != 0) begin
         errors++; $display("FAIL frozen_next: granted %0d want 0", obs);
      end
   endtask

   // Load ages in lockstep with store and wins the tie on lower index, so
   // store is due at most one arbitration after its counter saturates.
   task automatic test_starvation();
      int obs;
      int store_at;
      quiesce();
      store_at = -1;
      req_vec = 3'b111;
      bus.port_req_i = req_vec;
      for (int k = 1; k <= MAXW + 4 && store_at < 0; k++) begin
         arbitrate($urandom_range(0, 1), $urandom_range(1, 2), 3'b011, XLEN'($urandom), obs);
         if (obs == 2) store_at = k;
      end
      checks++;
      if (store_at < 0 || store_at > MAXW + 2) begin
         errors++; $display("FAIL starvation: store granted at arbitration %0d want 1..%0d",
                            store_at, MAXW + 2);
      end
      checks++;
      if (dbg_age[2] !== '0) begin
         errors++; $display("FAIL starve_age: got %0d want 0", dbg_age[2]);
      end
      check_ages("starve");
   endtask

   task automatic test_reset_in_busy();
      int w, obs;
      quiesce();
      req_vec = 3'b100;
      bus.port_req_i = req_vec;
      grant_phase(0, '0, -1, 3'b000, XLEN'($urandom), w, obs);
      rst_n = 1'b0;
      #1;
      checks++;
      if (dbg_state !== ARB_IDLE || bus.busy_o !== 1'b0) begin
         errors++; $display("FAIL rst_busy: state=%0d busy=%b want %0d 0", dbg_state, bus.busy_o, ARB_IDLE);
      end
      step();
      rst_n = 1'b1;
      model_reset();
      exp_q.delete();
      bus.cache_done_i  = 1'b1;
      bus.cache_rdata_i = XLEN'($urandom);
      #2;
      checks++;
      if (bus.port_rvalid_o !== '0 || bus.port_rdata_o !== '0) begin
         errors++; $display("FAIL rst_no_rvalid: rvalid=%b rdata=%h want 000 0",
                            bus.port_rvalid_o, bus.port_rdata_o);
      end
      step();
      bus.cache_done_i = 1'b0;
      checks++;
      if (dbg_state !== ARB_IDLE) begin
         errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ARB_IDLE);
      end
      req_vec = 3'b010;
      bus.port_req_i = req_vec;
      arbitrate(1, 2, 3'b000, XLEN'($urandom), obs);
      checks++;
      if (obs != 1) begin
         errors++; $display("FAIL rst_regrant: granted %0d want 1", obs);
      end
   endtask

   task automatic test_protocol_error();
      logic [XLEN-1:0] rd;
      bus.cache_done_i  = 1'b1;
      bus.cache_rdata_i = XLEN'($urandom);
      #2;
      checks++;
      if (bus.port_rvalid_o !== '0 || bus.port_gnt_o !== '0 || bus.cache_req_o !== 1'b0
          || bus.busy_o !== 1'b0) begin
         errors++; $display("FAIL idle_done_outputs: rvalid=%b gnt=%b req=%b busy=%b want all 0",
                            bus.port_rvalid_o, bus.port_gnt_o, bus.cache_req_o, bus.busy_o);
      end
      checks++;
      if (dbg_proto_err !== 1'b1) begin
         errors++; $display("FAIL idle_done_flag: got %b want 1", dbg_proto_err);
      end
      step();
      bus.cache_done_i = 1'b0;
      checks++;
      if (dbg_state !== ARB_IDLE) begin
         errors++; $display("FAIL idle_done_state: got %0d want %0d", dbg_state, ARB_IDLE);
      end
      // Owner drops its request while waiting for gnt: request must persist.
      req_vec = 3'b010;
      bus.port_req_i = req_vec;
      step();
      req_vec = '0;
      bus.port_req_i = req_vec;
      #2;
      checks++;
      if (bus.cache_req_o !== 1'b1 || bus.cache_port_sel_o !== LOAD_UNIT_PORT || dbg_proto_err !== 1'b1) begin
         errors++; $display("FAIL drop_wait: req=%b sel=%0d err=%b want 1 1 1",
                            bus.cache_req_o, bus.cache_port_sel_o, dbg_proto_err);
      end
      step();
      bus.cache_gnt_i = 1'b1;
      #2;
      checks++;
      if (bus.port_gnt_o !== 3'b010) begin
         errors++; $display("FAIL drop_gnt: got %b want 010", bus.port_gnt_o);
      end
      rd = XLEN'($urandom);
      exp_q.push_back(rd);
      model_grant(1);
      step();
      bus.cache_gnt_i = 1'b0;
      busy_phase(1, 1);
      check_ages("drop");
   endtask

   task automatic test_random();
      int w, obs, gd, lc;
      logic [N-1:0] late;
      quiesce();
      for (int t = 0; t < 30; t++) begin
         req_vec = req_vec | N'($urandom_range(1, 7));
         bus.port_req_i = req_vec;
         gd   = $urandom_range(0, 3);
         late = N'($urandom_range(0, 7));
         lc   = (gd > 0) ? $urandom_range(1, gd) : -1;
         grant_phase(gd, late, lc, N'($urandom_range(0, 7)), XLEN'($urandom), w, obs);
         busy_phase(w, $urandom_range(1, 3));
         check_ages("rand");
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      bus.port_req_i    = '0;
      bus.cache_gnt_i   = 1'b0;
      bus.cache_done_i  = 1'b0;
      bus.cache_rdata_i = '0;
      req_vec           = '0;
      model_reset();
      test_reset();
      test_single_load();
      test_priority();
      test_frozen_select();
      test_starvation();
      test_reset_in_busy();
      test_protocol_error();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: bench did not complete within time limit");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
